// File: rtl/ntt_stream_driver_if.sv
// ntt_stream_driver_if
// Bundles the driver's command/status, host coefficient stream, result stream
// and NTT core serial interface.
//   master : the driver (ntt_stream_driver) side
//   slave  : host + core side (adapter / testbench)
interface ntt_stream_driver_if #(
   parameter int DATA_SIZE_ARB = 32
);
   // command / status
   logic                     cmd_go;
   logic                     cmd_intt;
   logic                     busy;
   logic                     run_done;
   logic                     err_timeout;
   // host coefficient input stream
   logic                     host_valid;
   logic [DATA_SIZE_ARB-1:0] host_data;
   logic                     host_ready;
   // result output stream
   logic                     res_valid;
   logic [DATA_SIZE_ARB-1:0] res_data;
   logic                     res_last;
   logic                     res_ready;
   // NTT core serial interface
   logic                     ntt_load_b;
   logic                     ntt_start;
   logic                     ntt_start_intt;
   logic [DATA_SIZE_ARB-1:0] ntt_din;
   logic                     ntt_done;
   logic [DATA_SIZE_ARB-1:0] ntt_dout;

   modport master (
      input  cmd_go, cmd_intt, host_valid, host_data, res_ready, ntt_done, ntt_dout,
      output busy, run_done, err_timeout, host_ready, res_valid, res_data, res_last,
             ntt_load_b, ntt_start, ntt_start_intt, ntt_din
   );

   modport slave (
      output cmd_go, cmd_intt, host_valid, host_data, res_ready, ntt_done, ntt_dout,
      input  busy, run_done, err_timeout, host_ready, res_valid, res_data, res_last,
             ntt_load_b, ntt_start, ntt_start_intt, ntt_din
   );
endinterface

// File: rtl/ntt_stream_driver.sv
// ntt_stream_driver
// Host-side sequencer for the NTT core. Buffers one polynomial from the host
// stream, loads it serially into the core, fires start/start_intt, waits for
// done (with timeout), captures the serial result into the same buffer and
// drains it back to the host over valid/ready.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ntt_stream_driver_if.master (command/status, host in, result out,
//           core load/start/done/din/dout)
module ntt_stream_driver #(
   parameter int DATA_SIZE_ARB = 32,
   parameter int RING_DEPTH    = 10,
   parameter int RING_SIZE     = 1 << RING_DEPTH,
   parameter int DONE_TIMEOUT  = 65535
) (
   input  logic clk,
   input  logic reset,
   ntt_stream_driver_if.master bus
);
   localparam int CW = RING_DEPTH + 1;
   localparam int TW = ($clog2(DONE_TIMEOUT + 1) > 16) ? $clog2(DONE_TIMEOUT + 1) : 16;
   localparam logic [CW-1:0]         LAST    = CW'(RING_SIZE - 1);
   localparam logic [CW-1:0]         ONE_C   = CW'(1);
   localparam logic [RING_DEPTH-1:0] ONE_A   = RING_DEPTH'(1);
   localparam logic [TW-1:0]         ONE_T   = TW'(1);
   localparam logic [TW-1:0]         TMO_MAX = TW'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_LOAD, S_STRM, S_START, S_WAIT, S_CAPT, S_DRAIN
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [TW-1:0]       tmo, tmo_nxt;
   logic                mode_q, mode_nxt;
   logic                err_q, err_nxt;
   logic                done_q, done_nxt;

   // shared input/result buffer, one-cycle registered read
   logic [DATA_SIZE_ARB-1:0] mem [RING_SIZE];
   logic                     mem_we;
   logic [RING_DEPTH-1:0]    mem_wa;
   logic [DATA_SIZE_ARB-1:0] mem_wd;
   logic                     rd_en;
   logic [RING_DEPTH-1:0]    rd_addr;
   logic [DATA_SIZE_ARB-1:0] rd_data;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      // rd_data only moves on rd_en, which is what holds res_data during a stall
      if (rd_en)  rd_data     <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         tmo    <= '0;
         mode_q <= 1'b0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         tmo    <= tmo_nxt;
         mode_q <= mode_nxt;
         err_q  <= err_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt          = state;
      cnt_nxt            = cnt;
      tmo_nxt            = tmo;
      mode_nxt           = mode_q;
      err_nxt            = err_q;
      done_nxt           = 1'b0;
      mem_we             = 1'b0;
      mem_wa             = cnt[RING_DEPTH-1:0];
      mem_wd             = bus.host_data;
      rd_en              = 1'b0;
      rd_addr            = '0;
      bus.host_ready     = 1'b0;
      bus.res_valid      = 1'b0;
      bus.res_data       = '0;
      bus.res_last       = 1'b0;
      bus.ntt_load_b     = 1'b0;
      bus.ntt_start      = 1'b0;
      bus.ntt_start_intt = 1'b0;
      bus.ntt_din        = '0;
      bus.busy           = (state != S_IDLE);
      bus.run_done       = done_q;
      bus.err_timeout    = err_q;

      case (state)
         S_IDLE: begin
            if (bus.cmd_go) begin
               mode_nxt  = bus.cmd_intt;
               err_nxt   = 1'b0;
               cnt_nxt   = '0;
               state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            bus.host_ready = 1'b1;
            if (bus.host_valid) begin
               mem_we  = 1'b1;
               cnt_nxt = cnt + ONE_C;
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            // word 0 is fetched here so it is on ntt_din in the first STRM cycle
            bus.ntt_load_b = 1'b1;
            rd_en          = 1'b1;
            rd_addr        = '0;
            state_nxt      = S_STRM;
         end
         S_STRM: begin
            // present word cnt, fetch word cnt+1 (wraps harmlessly on the last word)
            bus.ntt_din = rd_data;
            rd_en       = 1'b1;
            rd_addr     = cnt[RING_DEPTH-1:0] + ONE_A;
            cnt_nxt     = cnt + ONE_C;
            if (cnt == LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_START;
            end
         end
         S_START: begin
            bus.ntt_start      = ~mode_q;
            bus.ntt_start_intt = mode_q;
            tmo_nxt            = '0;
            state_nxt          = S_WAIT;
         end
         S_WAIT: begin
            if (bus.ntt_done) begin
               cnt_nxt   = '0;
               state_nxt = S_CAPT;
            end else if (tmo == TMO_MAX) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               tmo_nxt = tmo + ONE_T;
            end
         end
         S_CAPT: begin
            mem_we  = 1'b1;
            mem_wd  = bus.ntt_dout;
            cnt_nxt = cnt + ONE_C;
            if (cnt == LAST) begin
               // prefetch result word 0 so DRAIN has valid data on entry
               cnt_nxt   = '0;
               rd_en     = 1'b1;
               rd_addr   = '0;
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            bus.res_valid = 1'b1;
            bus.res_data  = rd_data;
            bus.res_last  = (cnt == LAST);
            if (bus.res_ready) begin
               rd_en   = 1'b1;
               rd_addr = cnt[RING_DEPTH-1:0] + ONE_A;
               cnt_nxt = cnt + ONE_C;
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ntt_stream_driver.sv
// tb_ntt_stream_driver
// Directed bench for ntt_stream_driver with RING_SIZE=16, DONE_TIMEOUT=40.
// A behavioural core answers start with done 20 cycles later and returns
// din+1 serially. Stimulus is driven and outputs sampled on the falling edge.
module tb_ntt_stream_driver;
   localparam int DW  = 32;
   localparam int RD  = 4;
   localparam int RS  = 16;
   localparam int TMO = 40;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ntt_stream_driver_if #(.DATA_SIZE_ARB(DW)) bus();

   ntt_stream_driver #(
      .DATA_SIZE_ARB(DW), .RING_DEPTH(RD), .RING_SIZE(RS), .DONE_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(rst_n), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic          core_done = 1'b0;
   logic          spur_done = 1'b0;
   logic [DW-1:0] core_dout = '0;
   bit            core_en   = 1'b1;
   assign bus.ntt_done = core_done | spur_done;
   assign bus.ntt_dout = core_dout;

   // strobe / din monitor (cumulative counts; runs take deltas)
   int cyc = 0, n_load = 0, n_start = 0, n_intt = 0, n_multi = 0, n_rdone = 0;
   int load_cyc = -1000, start_cyc = -1000;
   logic [DW-1:0] din_log [RS];
   always @(negedge clk) begin
      cyc++;
      if (bus.ntt_load_b)     begin n_load++;  load_cyc  = cyc; end
      if (bus.ntt_start)      begin n_start++; start_cyc = cyc; end
      if (bus.ntt_start_intt) begin n_intt++;  start_cyc = cyc; end
      if (int'(bus.ntt_load_b) + int'(bus.ntt_start) + int'(bus.ntt_start_intt) > 1) n_multi++;
      if (bus.run_done) n_rdone++;
      if (cyc > load_cyc && cyc <= load_cyc + RS) din_log[cyc-load_cyc-1] = bus.ntt_din;
   end

   // core model: done 20 cycles after start, then dout = din+1 for RS cycles
   int cst = 0, cw = 0, ck = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         cst = 0; core_done = 1'b0; core_dout = '0;
      end else begin
         case (cst)
            0: if (core_en && (bus.ntt_start || bus.ntt_start_intt)) begin cst = 1; cw = 1; end
            1: if (cw == 20) begin core_done = 1'b1; cst = 2; ck = 0; end else cw++;
            2: begin
               core_done = 1'b0;
               core_dout = din_log[ck] + 1;
               ck++;
               if (ck == RS) cst = 3;
            end
            default: begin core_dout = '0; cst = 0; end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic go(input bit intt);
      bus.cmd_go = 1'b1; bus.cmd_intt = intt;
      tick;
      bus.cmd_go = 1'b0; bus.cmd_intt = 1'b0;
      chk("go_busy", 64'(bus.busy), 64'd1);
      chk("go_err_clr", 64'(bus.err_timeout), 64'd0);
   endtask

   task automatic fill(input logic [DW-1:0] base, input bit gaps, input bit spur);
      int i, n;
      bit v;
      i = 0; n = 0;
      while (i < RS && n < 200) begin
         v = gaps ? (n % 2 == 0) : 1'b1;
         bus.host_valid = v;
         bus.host_data  = base + DW'(i);
         spur_done      = spur && (n == 5);
         if (v && bus.host_ready) i++;
         tick; n++;
      end
      bus.host_valid = 1'b0; spur_done = 1'b0;
      chk("fill_cnt", 64'(i), 64'(RS));
      chk("fill_ready_drop", 64'(bus.host_ready), 64'd0);
   endtask

   task automatic drain(input logic [DW-1:0] base, input bit rnd, input string nm);
      int j, n;
      bit r, stall;
      logic [DW:0]   hold;
      logic [RS-1:0] lasts;
      j = 0; n = 0; stall = 1'b0; hold = '0; lasts = '0;
      while (j < RS && n < 400) begin
         r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (stall && bus.res_valid)
            chk({nm, "_hold"}, 64'({bus.res_last, bus.res_data}), 64'(hold));
         bus.res_ready = r;
         if (bus.res_valid) begin
            if (r) begin
               chk($sformatf("%s_res%0d", nm, j), 64'(bus.res_data), 64'(base + DW'(j) + 1));
               lasts[j] = bus.res_last;
               j++; stall = 1'b0;
            end else begin
               stall = 1'b1; hold = {bus.res_last, bus.res_data};
            end
         end
         tick; n++;
      end
      bus.res_ready = 1'b0;
      chk({nm, "_res_cnt"}, 64'(j), 64'(RS));
      chk({nm, "_last_pos"}, 64'(lasts), 64'h8000);
      chk({nm, "_run_done"}, 64'(bus.run_done), 64'd1);
      chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
      tick;
      chk({nm, "_run_done_pulse"}, 64'(bus.run_done), 64'd0);
   endtask

   task automatic run(input bit intt, input logic [DW-1:0] base, input bit gaps,
                      input bit rnd, input bit spur, input string nm);
      int l0, s0, i0, m0, r0;
      l0 = n_load; s0 = n_start; i0 = n_intt; m0 = n_multi; r0 = n_rdone;
      go(intt);
      fill(base, gaps, spur);
      if (spur) begin
         // now in LOAD; three cycles later the driver is mid-STRM
         repeat (3) tick;
         bus.cmd_go = 1'b1; bus.cmd_intt = ~intt;
         tick;
         bus.cmd_go = 1'b0; bus.cmd_intt = 1'b0;
      end
      drain(base, rnd, nm);
      chk({nm, "_load_pulses"}, 64'(n_load - l0), 64'd1);
      chk({nm, "_start_pulses"}, 64'(n_start - s0), intt ? 64'd0 : 64'd1);
      chk({nm, "_intt_pulses"}, 64'(n_intt - i0), intt ? 64'd1 : 64'd0);
      chk({nm, "_start_offset"}, 64'(start_cyc - load_cyc), 64'(RS + 1));
      chk({nm, "_multi_strobe"}, 64'(n_multi - m0), 64'd0);
      chk({nm, "_run_done_cnt"}, 64'(n_rdone - r0), 64'd1);
      for (int k = 0; k < RS; k++)
         chk($sformatf("%s_din%0d", nm, k), 64'(din_log[k]), 64'(base + DW'(k)));
   endtask

   task automatic timeout_test;
      int n, r0;
      r0 = n_rdone; core_en = 1'b0;
      go(1'b0);
      fill(32'h300, 1'b0, 1'b0);
      n = 0;
      while (!bus.ntt_start && n < 100) begin tick; n++; end
      chk("tmo_start_seen", 64'(bus.ntt_start), 64'd1);
      repeat (TMO) tick;
      chk("tmo_last_wait_busy", 64'(bus.busy), 64'd1);
      chk("tmo_last_wait_err", 64'(bus.err_timeout), 64'd0);
      tick;
      chk("tmo_idle", 64'(bus.busy), 64'd0);
      chk("tmo_err_set", 64'(bus.err_timeout), 64'd1);
      tick;
      chk("tmo_err_sticky", 64'(bus.err_timeout), 64'd1);
      chk("tmo_no_run_done", 64'(n_rdone - r0), 64'd0);
      core_en = 1'b1;
   endtask

   task automatic reset_test;
      go(1'b0);
      fill(32'h400, 1'b0, 1'b0);
      repeat (8) tick;  // load + 8 cycles: word 7 on ntt_din
      chk("rst_pre_din", 64'(bus.ntt_din), 64'h407);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_din", 64'(bus.ntt_din), 64'd0);
      chk("rst_strobes", 64'({bus.ntt_load_b, bus.ntt_start, bus.ntt_start_intt}), 64'd0);
      chk("rst_host_ready", 64'(bus.host_ready), 64'd0);
      chk("rst_res", 64'({bus.res_valid, bus.res_last, bus.res_data}), 64'd0);
      chk("rst_flags", 64'({bus.run_done, bus.err_timeout}), 64'd0);
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.cmd_go = 1'b0; bus.cmd_intt = 1'b0;
      bus.host_valid = 1'b0; bus.host_data = '0; bus.res_ready = 1'b0;
      repeat (3) tick;
      chk("init_busy", 64'(bus.busy), 64'd0);
      chk("init_strobes", 64'({bus.ntt_load_b, bus.ntt_start, bus.ntt_start_intt}), 64'd0);
      chk("init_din", 64'(bus.ntt_din), 64'd0);
      chk("init_host_ready", 64'(bus.host_ready), 64'd0);
      chk("init_res", 64'({bus.res_valid, bus.res_last, bus.res_data}), 64'd0);
      chk("init_flags", 64'({bus.run_done, bus.err_timeout}), 64'd0);
      rst_n = 1'b1;
      tick;

      run(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, "fwd");
      run(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, "inv");
      run(1'b0, 32'h100, 1'b1, 1'b1, 1'b0, "bp");
      timeout_test;
      run(1'b0, 32'h600, 1'b0, 1'b0, 1'b1, "spur");
      reset_test;
      run(1'b0, 32'h500, 1'b0, 1'b0, 1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ntt_stream_driver.md
Name: ntt_stream_driver

Overview:
- Host-side sequencer that drives the NTT core's serial load/start/done interface. It is the transmitter for the core's coefficient input and the receiver for its serial dout stream.
- Buffers one polynomial from a valid/ready host stream, issues load_b, streams the coefficients and pulses start or start_intt. It then waits for done, captures the serial result and drains it back to the host over valid/ready.
- Sits between the host/AXI adapter and the NTT top, replacing hand-driven testbench strobes.

Parameters:
- DATA_SIZE_ARB, 32, coefficient width.
- RING_DEPTH, 10, log2 of polynomial length.
- RING_SIZE, 1<<RING_DEPTH, coefficients per polynomial.
- DONE_TIMEOUT, 65535, maximum cycles to wait for ntt_done before aborting.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset: reset==0 clears all state immediately.
- cmd_go  in  1  one-cycle request to run one transform; sampled only in IDLE.
- cmd_intt  in  1  mode, sampled with cmd_go: 0 selects forward NTT, 1 selects inverse.
- host_valid  in  1  input coefficient valid.
- host_data  in  DATA_SIZE_ARB  input coefficient, natural order.
- host_ready  out  1  driver accepts host_data this cycle.
- res_valid  out  1  result coefficient valid.
- res_data  out  DATA_SIZE_ARB  result coefficient.
- res_last  out  1  marks coefficient RING_SIZE-1 of the result.
- res_ready  in  1  host accepts the result word.
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse after the last result word is accepted.
- err_timeout  out  1  sticky flag; cleared by the next accepted cmd_go.
- ntt_load_b  out  1  one-cycle strobe to the core.
- ntt_start  out  1  one-cycle strobe to the core.
- ntt_start_intt  out  1  one-cycle strobe to the core.
- ntt_din  out  DATA_SIZE_ARB  coefficient stream to the core.
- ntt_done  in  1  core completion pulse.
- ntt_dout  in  DATA_SIZE_ARB  core serial result stream.

Behaviour:
- Reset: every output is 0. State is IDLE. All counters are 0. The buffer contents are don't-care.
- Buffer: single RING_SIZE x DATA_SIZE_ARB RAM with one-cycle read latency. It is reused for input and for result.
- States: IDLE, FILL, LOAD, STRM, START, WAIT, CAPT, DRAIN.
- IDLE:
  - cmd_go=1 latches cmd_intt, clears err_timeout and goes to FILL.
  - cmd_go in any other state is ignored.
- FILL:
  - host_ready=1.
  - A handshake (host_valid & host_ready) writes buf[cnt] and increments cnt.
  - After handshake number RING_SIZE, host_ready drops the next cycle and the state goes to LOAD.
  - Gaps in host_valid are allowed.
- LOAD: ntt_load_b=1 for exactly one cycle; call this cycle L. The buffer read of address 0 is issued in the same cycle.
- STRM:
  - ntt_din = buf[k] in cycle L+1+k, for k = 0..RING_SIZE-1, with no gaps.
  - ntt_din is 0 outside STRM.
- START:
  - Cycle L+RING_SIZE+1.
  - Exactly one of ntt_start / ntt_start_intt is high for one cycle, selected by the latched mode.
- WAIT:
  - The timeout counter starts at 0 and increments each cycle.
  - ntt_done=1 goes to CAPT; call that cycle D.
  - If the counter reaches DONE_TIMEOUT with no done: set err_timeout, go to IDLE, no run_done.
- CAPT:
  - ntt_dout sampled in cycle D+1+k is written to buf[k], for k = 0..RING_SIZE-1.
  - The state then goes to DRAIN.
  - No backpressure is possible toward the core.
- ntt_done in any state other than WAIT is ignored.
- DRAIN:
  - res_valid=1 and res_data=buf[j], with res_last=1 when j = RING_SIZE-1.
  - res_data and res_last are held stable while res_valid & !res_ready.
  - j advances only on a handshake. Prefetch the next word so back-to-back handshakes sustain one word per cycle.
  - The last handshake pulses run_done the next cycle, and the state returns to IDLE.
- Counter widths: RING_DEPTH+1 bits for word counters, so RING_SIZE is reachable without wrap. The timeout counter is 16 bits minimum.
- Reset asserted mid-operation: abort immediately to IDLE with all strobes 0. A partial FILL is discarded.
- Strobes: never more than one of ntt_load_b / ntt_start / ntt_start_intt is high in any cycle.

Test Plan (RING_DEPTH=4, RING_SIZE=16, DONE_TIMEOUT=40):
- Forward run:
  - Stimulus: cmd_go, cmd_intt=0, host words 0x100..0x10F, core model pulses done 20 cycles after start and returns dout = din+1.
  - Required response: ntt_load_b one pulse, ntt_din 0x100..0x10F on 16 consecutive cycles, ntt_start pulse in the next cycle, results 0x101..0x110 with res_last on the 16th word, run_done pulse.
- Inverse mode: same run with cmd_intt=1 -> only ntt_start_intt pulses and ntt_start stays 0.
- Backpressure:
  - Stimulus: host_valid toggled every other cycle; res_ready random at 50%.
  - Required response: identical data sequences to the forward run, and res_data stable while stalled.
- Timeout:
  - Stimulus: core never asserts done.
  - Required response: err_timeout=1 after 40 WAIT cycles, state IDLE, busy=0, no run_done. The next cmd_go clears err_timeout.
- Spurious inputs:
  - Stimulus: cmd_go during STRM and ntt_done during FILL.
  - Required response: both ignored, and the transform completes normally.
- Reset during STRM:
  - Stimulus: reset=0 at word 7.
  - Required response: all outputs 0 immediately, busy=0. A fresh run afterwards produces correct results.
